// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_if
// Brief    : Requester-side and memory-side bundle of the 4-port memory arbiter
// Revision : 1.0
// ============================================================================
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8
);
    logic                           en_i;
    logic [3:0]                     req_i;
    logic [3:0]                     we_i;
    logic [3:0][ADDR_WIDTH-1:0]     addr_i;
    logic [3:0][DATA_WIDTH-1:0]     wdata_i;
    logic [3:0]                     ack_o;
    logic [3:0][DATA_WIDTH-1:0]     rdata_o;
    logic                           busy_o;
    logic [1:0]                     grant_id_o;
    logic                           mem_en_o;
    logic                           mem_read_o;
    logic                           mem_write_o;
    logic [ADDR_WIDTH-1:0]          mem_address_o;
    logic [DATA_WIDTH-1:0]          mem_wdata_o;
    logic [DATA_WIDTH-1:0]          mem_rdata_i;

    modport slave (
        input  en_i, req_i, we_i, addr_i, wdata_i, mem_rdata_i,
        output ack_o, rdata_o, busy_o, grant_id_o,
        output mem_en_o, mem_read_o, mem_write_o, mem_address_o, mem_wdata_o
    );

    modport master (
        output en_i, req_i, we_i, addr_i, wdata_i, mem_rdata_i,
        input  ack_o, rdata_o, busy_o, grant_id_o,
        input  mem_en_o, mem_read_o, mem_write_o, mem_address_o, mem_wdata_o
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Round-robin sequencer sharing one single-ported memory among four
//            requesters, one registered transaction in flight at a time
// Revision : 1.0
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_WIDTH   = 7,
    parameter int DATA_WIDTH   = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_t;

    localparam logic [1:0] C_WAIT_LAST = (READ_LATENCY > 0) ? 2'(READ_LATENCY - 1) : 2'd0;

    state_t                         state_q, state_d;
    logic [1:0]                     grant_q, grant_d;
    logic [1:0]                     rr_q, rr_d;
    logic [1:0]                     cnt_q, cnt_d;
    logic                           we_q, we_d;
    logic                           mem_en_q, mem_en_d;
    logic                           mem_read_q, mem_read_d;
    logic                           mem_write_q, mem_write_d;
    logic [ADDR_WIDTH-1:0]          mem_address_q, mem_address_d;
    logic [DATA_WIDTH-1:0]          mem_wdata_q, mem_wdata_d;
    logic [3:0]                     ack_q, ack_d;
    logic                           busy_q, busy_d;
    logic [3:0][DATA_WIDTH-1:0]     rdata_q;
    logic                           capture;
    logic                           found;
    logic [1:0]                     sel;
    logic [1:0]                     idx;

    // Search starts just after the last winner, so it becomes lowest priority.
    always_comb begin
        found = 1'b0;
        sel   = rr_q;
        idx   = '0;
        for (int k = 1; k <= 4; k++) begin
            idx = rr_q + 2'(k);
            if (!found && bus.req_i[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    // Memory controls are computed for the next state so they leave a flop.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        rr_d          = rr_q;
        cnt_d         = cnt_q;
        we_d          = we_q;
        mem_en_d      = 1'b0;
        mem_read_d    = 1'b0;
        mem_write_d   = 1'b0;
        mem_address_d = mem_address_q;
        mem_wdata_d   = mem_wdata_q;
        ack_d         = '0;
        capture       = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.en_i && found) begin
                    state_d       = ISSUE;
                    grant_d       = sel;
                    rr_d          = sel;
                    we_d          = bus.we_i[sel];
                    mem_address_d = bus.addr_i[sel];
                    mem_wdata_d   = bus.wdata_i[sel];
                    mem_en_d      = 1'b1;
                    mem_write_d   = bus.we_i[sel];
                    mem_read_d    = !bus.we_i[sel];
                end
            end
            ISSUE: begin
                if (we_q || READ_LATENCY == 0) begin
                    state_d         = ACK;
                    ack_d[grant_q]  = 1'b1;
                    capture         = !we_q;
                end else begin
                    state_d    = WAIT;
                    cnt_d      = '0;
                    mem_en_d   = 1'b1;
                    mem_read_d = 1'b1;
                end
            end
            WAIT: begin
                if (cnt_q == C_WAIT_LAST) begin
                    state_d        = ACK;
                    ack_d[grant_q] = 1'b1;
                    capture        = 1'b1;
                end else begin
                    cnt_d      = cnt_q + 2'd1;
                    mem_en_d   = 1'b1;
                    mem_read_d = 1'b1;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            rr_q          <= 2'd3;
            cnt_q         <= '0;
            we_q          <= 1'b0;
            mem_en_q      <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
            ack_q         <= '0;
            busy_q        <= 1'b0;
            rdata_q       <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            rr_q          <= rr_d;
            cnt_q         <= cnt_d;
            we_q          <= we_d;
            mem_en_q      <= mem_en_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
            ack_q         <= ack_d;
            busy_q        <= busy_d;
            if (capture) begin
                rdata_q[grant_q] <= bus.mem_rdata_i;
            end
        end
    end

    assign bus.ack_o         = ack_q;
    assign bus.rdata_o       = rdata_q;
    assign bus.busy_o        = busy_q;
    assign bus.grant_id_o    = grant_q;
    assign bus.mem_en_o      = mem_en_q;
    assign bus.mem_read_o    = mem_read_q;
    assign bus.mem_write_o   = mem_write_q;
    assign bus.mem_address_o = mem_address_q;
    assign bus.mem_wdata_o   = mem_wdata_q;
endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Round-robin arbiter/sequencer that shares the single-ported 128x8 data memory between four requesters (fetch, load/store, stack, I/O).
- Replaces the combinational port-select path with a registered request/acknowledge protocol.
- Exactly one memory transaction is in flight at a time; all memory control lines are registered.
- Sits between the four requester blocks and the memory instance.

Parameters:
ADDR_WIDTH, 7, memory address width
DATA_WIDTH, 8, memory data width
READ_LATENCY, 1, cycles from the ISSUE cycle until mem_rdata is valid; legal range 0..3

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
en  input  1  global enable; gates new grants only
req0..req3  input  1 each  transaction request, held until ack
we0..we3  input  1 each  1 = write, 0 = read; stable while req is high
addr0..addr3  input  ADDR_WIDTH each  address; stable while req is high
wdata0..wdata3  input  DATA_WIDTH each  write data; stable while req is high
ack0..ack3  output  1 each  one-cycle completion pulse
rdata0..rdata3  output  DATA_WIDTH each  per-port read data register
busy  output  1  high in any state other than IDLE
grant_id  output  2  index of the current or last granted port
mem_en, mem_read, mem_write  output  1 each  memory controls
mem_address  output  ADDR_WIDTH  memory address
mem_wdata  output  DATA_WIDTH  memory write data
mem_rdata  input  DATA_WIDTH  memory read data

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transaction):
  - state = IDLE.
  - All ack, mem_*, busy and grant_id outputs = 0.
  - rdata0..3 = 0.
  - rr_last = 3, so port 0 has highest priority first.
  - Any in-flight transaction is abandoned with no ack.
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - If en=1 and any req is high, select the first requester with req=1 searching rr_last+1, rr_last+2, ... modulo 4.
  - Latch its index into grant_id, and latch its we, addr and wdata into internal registers.
  - Set rr_last = the granted index, then go to ISSUE.
  - Otherwise stay in IDLE; mem_en = 0.
- ISSUE (one cycle): mem_en=1, mem_address=latched address.
  - Write: mem_write=1, mem_wdata=latched wdata; next state ACK.
  - Read: mem_read=1.
    - READ_LATENCY=0: capture mem_rdata into rdata[grant_id] at the end of this cycle; next state ACK.
    - READ_LATENCY>0: next state WAIT.
- WAIT (read only, lasts READ_LATENCY cycles, counted by a 2-bit counter):
  - mem_en, mem_read and mem_address are held.
  - Capture mem_rdata into rdata[grant_id] at the end of the last WAIT cycle; next state ACK.
- ACK (one cycle):
  - mem_en, mem_read, mem_write = 0.
  - ack[grant_id] = 1 for exactly this cycle; next state IDLE.
- Latency from req sampled in IDLE (cycle 0):
  - Write: ack in cycle 2, IDLE again in cycle 3.
  - Read: ack in cycle 2+READ_LATENCY.
  - Peak throughput is one transaction per 3 (write) or 3+READ_LATENCY (read) cycles.
- Requester contract:
  - Deassert req at the same clock edge that samples ack=1.
  - A req still high in the following IDLE cycle is a new transaction.
- rdataN holds its value until the next completed read for port N. Writes never modify rdataN.
- Fairness: a port that has just been granted has lowest priority on the next arbitration. Any continuously requesting port is granted within 4 transactions.
- en=0 suppresses new grants in IDLE only; an in-flight transaction completes and acks normally.
- Signal changes on a non-granted port have no effect. Changes on the granted port after IDLE are ignored because all fields are latched.
- mem_read and mem_write are never both 1. Exactly one ackN is high in ACK; all ack lines are 0 in every other state.

Test Plan:
1. Reset; port0 writes 0xA5 to address 0x12, then reads 0x12 (READ_LATENCY=1) -> write ack0 in cycle 2; read ack0 in cycle 3 with rdata0=0xA5; mem_write high in exactly one cycle.
2. After reset, req0..req3 all held high, each writing its own index to address 0x40+index -> grant_id sequence 0,1,2,3 with acks 3 cycles apart; memory ends with 0x40..0x43 = 0,1,2,3.
3. Ports 1 and 2 request continuously with reads -> grants alternate 1,2,1,2; neither port waits more than one foreign transaction.
4. en=0 with req3 high for 10 cycles -> busy=0, no mem_en; raise en -> ISSUE on the next cycle. Drop en during WAIT -> ack still issued.
5. Assert reset during WAIT of a port2 read -> ack2 never pulses, rdata2=0, mem_en=0 immediately; after release, req0 is granted first.
6. READ_LATENCY=0 build: read of an address holding 0x3C -> ack in cycle 2, rdataN=0x3C, no WAIT state visited.
